// File: rtl/cache_refill_ctrl.sv
// Cache refill controller: serves I/D misses over an AXI-like bus,
// writing back a dirty D victim before refilling the block beat by beat.
module cache_refill_ctrl #(
    parameter int unsigned ADDR_WIDTH  = 64,
    parameter int unsigned BLOCK_WIDTH = 512,
    parameter int unsigned BEAT_WIDTH  = 64
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_icache_hit,
    input  logic [ADDR_WIDTH-1:0]  i_read_addr_i,
    input  logic                   i_mem_access,
    input  logic                   i_dcache_hit,
    input  logic                   i_dcache_dirty,
    input  logic [ADDR_WIDTH-1:0]  i_read_addr_d,
    input  logic [ADDR_WIDTH-1:0]  i_addr_wb,
    input  logic [BLOCK_WIDTH-1:0] i_data_block,
    output logic [BLOCK_WIDTH-1:0] o_data_block,
    output logic                   o_instr_we,
    output logic                   o_dcache_we,
    output logic                   o_stall_i,
    output logic                   o_stall_d,
    output logic                   o_ar_valid,
    input  logic                   i_ar_ready,
    output logic [ADDR_WIDTH-1:0]  o_ar_addr,
    input  logic                   i_r_valid,
    input  logic [BEAT_WIDTH-1:0]  i_r_data,
    input  logic                   i_r_last,
    output logic                   o_aw_valid,
    input  logic                   i_aw_ready,
    output logic [ADDR_WIDTH-1:0]  o_aw_addr,
    output logic                   o_w_valid,
    output logic [BEAT_WIDTH-1:0]  o_w_data,
    output logic                   o_w_last,
    input  logic                   i_w_ready,
    input  logic                   i_b_valid,
    output logic                   o_proto_err
);

    localparam int unsigned BEATS = BLOCK_WIDTH / BEAT_WIDTH;
    localparam int unsigned CNT_W = $clog2(BEATS);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(BLOCK_WIDTH / 8 - 1);

    typedef enum logic [2:0] {
        IDLE,
        WB_ADDR,
        WB_DATA,
        WB_RESP,
        RD_ADDR,
        RD_DATA,
        FILL
    } state_t;

    state_t                 state_q, state_d;
    logic                   serve_d_q, serve_d_d;
    logic [ADDR_WIDTH-1:0]  rd_addr_q, rd_addr_d;
    logic [ADDR_WIDTH-1:0]  wb_addr_q, wb_addr_d;
    logic [BLOCK_WIDTH-1:0] victim_q, victim_d;
    logic [CNT_W-1:0]       beat_q, beat_d;
    logic [BLOCK_WIDTH-1:0] block_q, block_d;
    logic                   proto_err_q, proto_err_d;

    logic i_miss;
    logic d_miss;
    logic is_last;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q     <= IDLE;
            serve_d_q   <= 1'b0;
            rd_addr_q   <= '0;
            wb_addr_q   <= '0;
            victim_q    <= '0;
            beat_q      <= '0;
            block_q     <= '0;
            proto_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            serve_d_q   <= serve_d_d;
            rd_addr_q   <= rd_addr_d;
            wb_addr_q   <= wb_addr_d;
            victim_q    <= victim_d;
            beat_q      <= beat_d;
            block_q     <= block_d;
            proto_err_q <= proto_err_d;
        end
    end

    always_comb begin
        i_miss      = !i_icache_hit;
        d_miss      = i_mem_access && !i_dcache_hit;
        is_last     = (beat_q == LAST_BEAT);
        state_d     = state_q;
        serve_d_d   = serve_d_q;
        rd_addr_d   = rd_addr_q;
        wb_addr_d   = wb_addr_q;
        victim_d    = victim_q;
        beat_d      = beat_q;
        block_d     = block_q;
        proto_err_d = proto_err_q;

        case (state_q)
            IDLE: begin
                // D wins a same-cycle tie; the I miss stays pending in IDLE.
                if (d_miss || i_miss) begin
                    serve_d_d = d_miss;
                    rd_addr_d = (d_miss ? i_read_addr_d : i_read_addr_i) & ALIGN_MASK;
                    wb_addr_d = i_addr_wb & ALIGN_MASK;
                    victim_d  = i_data_block;
                    beat_d    = '0;
                    state_d   = (d_miss && i_dcache_dirty) ? WB_ADDR : RD_ADDR;
                end
            end
            WB_ADDR: begin
                if (i_aw_ready) state_d = WB_DATA;
            end
            WB_DATA: begin
                if (i_w_ready) begin
                    if (is_last) begin
                        beat_d  = '0;
                        state_d = WB_RESP;
                    end else begin
                        beat_d = beat_q + CNT_W'(1);
                    end
                end
            end
            WB_RESP: begin
                if (i_b_valid) state_d = RD_ADDR;
            end
            RD_ADDR: begin
                if (i_ar_ready) begin
                    beat_d  = '0;
                    state_d = RD_DATA;
                end
            end
            RD_DATA: begin
                // The beat count ends the burst; a misplaced r_last is only flagged.
                if (i_r_valid) begin
                    block_d[32'(beat_q) * BEAT_WIDTH +: BEAT_WIDTH] = i_r_data;
                    if (i_r_last != is_last) proto_err_d = 1'b1;
                    if (is_last) begin
                        beat_d  = '0;
                        state_d = FILL;
                    end else begin
                        beat_d = beat_q + CNT_W'(1);
                    end
                end
            end
            FILL: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        o_data_block = block_q;
        o_proto_err  = proto_err_q;
        o_ar_valid   = (state_q == RD_ADDR);
        o_ar_addr    = rd_addr_q;
        o_aw_valid   = (state_q == WB_ADDR);
        o_aw_addr    = wb_addr_q;
        o_w_valid    = (state_q == WB_DATA);
        o_w_data     = victim_q[32'(beat_q) * BEAT_WIDTH +: BEAT_WIDTH];
        o_w_last     = (state_q == WB_DATA) && is_last;
        o_instr_we   = (state_q == FILL) && !serve_d_q;
        o_dcache_we  = (state_q == FILL) && serve_d_q;
        if (state_q == IDLE) begin
            o_stall_i = i_miss;
            o_stall_d = d_miss;
        end else begin
            o_stall_i = serve_d_q ? i_miss : (state_q != FILL);
            o_stall_d = serve_d_q;
        end
    end

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Directed + randomized bench for cache_refill_ctrl; the slave side is driven
// inline and results compared against a block-level transaction model.
module tb_cache_refill_ctrl;

    localparam int unsigned AW  = 64;
    localparam int unsigned BLK = 512;
    localparam int unsigned BW  = 64;
    localparam int unsigned NB  = BLK / BW;
    localparam logic [AW-1:0] ALIGN = ~64'h3F;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           i_icache_hit = 1'b1;
    logic [AW-1:0]  i_read_addr_i = '0;
    logic           i_mem_access = 1'b0;
    logic           i_dcache_hit = 1'b1;
    logic           i_dcache_dirty = 1'b0;
    logic [AW-1:0]  i_read_addr_d = '0;
    logic [AW-1:0]  i_addr_wb = '0;
    logic [BLK-1:0] i_data_block = '0;
    logic [BLK-1:0] o_data_block;
    logic           o_instr_we, o_dcache_we, o_stall_i, o_stall_d;
    logic           o_ar_valid;
    logic           i_ar_ready = 1'b0;
    logic [AW-1:0]  o_ar_addr;
    logic           i_r_valid = 1'b0;
    logic [BW-1:0]  i_r_data = '0;
    logic           i_r_last = 1'b0;
    logic           o_aw_valid;
    logic           i_aw_ready = 1'b0;
    logic [AW-1:0]  o_aw_addr;
    logic           o_w_valid;
    logic [BW-1:0]  o_w_data;
    logic           o_w_last;
    logic           i_w_ready = 1'b0;
    logic           i_b_valid = 1'b0;
    logic           o_proto_err;

    cache_refill_ctrl #(.ADDR_WIDTH(AW), .BLOCK_WIDTH(BLK), .BEAT_WIDTH(BW)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_icache_hit(i_icache_hit), .i_read_addr_i(i_read_addr_i),
        .i_mem_access(i_mem_access), .i_dcache_hit(i_dcache_hit),
        .i_dcache_dirty(i_dcache_dirty), .i_read_addr_d(i_read_addr_d),
        .i_addr_wb(i_addr_wb), .i_data_block(i_data_block),
        .o_data_block(o_data_block), .o_instr_we(o_instr_we),
        .o_dcache_we(o_dcache_we), .o_stall_i(o_stall_i), .o_stall_d(o_stall_d),
        .o_ar_valid(o_ar_valid), .i_ar_ready(i_ar_ready), .o_ar_addr(o_ar_addr),
        .i_r_valid(i_r_valid), .i_r_data(i_r_data), .i_r_last(i_r_last),
        .o_aw_valid(o_aw_valid), .i_aw_ready(i_aw_ready), .o_aw_addr(o_aw_addr),
        .o_w_valid(o_w_valid), .o_w_data(o_w_data), .o_w_last(o_w_last),
        .i_w_ready(i_w_ready), .i_b_valid(i_b_valid), .o_proto_err(o_proto_err)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;
    logic [BW-1:0]  beats [NB];
    logic [BLK-1:0] victim;
    logic           exp_err = 1'b0;

    task automatic chk(input string tag, input logic [BLK-1:0] obs, input logic [BLK-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [AW-1:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    task automatic rand_beats();
        for (int k = 0; k < NB; k++) beats[k] = rnd64();
    endtask

    task automatic start_i(input logic [AW-1:0] a);
        i_icache_hit  = 1'b0;
        i_read_addr_i = a;
    endtask

    task automatic start_d(input bit dirty, input logic [AW-1:0] a, input logic [AW-1:0] wb);
        i_mem_access   = 1'b1;
        i_dcache_hit   = 1'b0;
        i_dcache_dirty = dirty;
        i_read_addr_d  = a;
        i_addr_wb      = wb;
        i_data_block   = victim;
    endtask

    // Plays memory for one miss starting in its IDLE detection cycle.
    task automatic run_service(input bit is_d, input bit dirty, input logic [AW-1:0] miss_addr,
                               input logic [AW-1:0] wb_addr, input int ar_wait, input int b_wait,
                               input bit w_toggle, input int last_at, input bit r_gaps);
        int unsigned n0;
        int          extra;
        int          k;
        bit          rdy;
        logic [BLK-1:0] exp_blk;
        extra = 0;
        for (int j = 0; j < NB; j++) exp_blk[j*BW +: BW] = beats[j];
        #1;
        chk("idle_stall_d", BLK'(o_stall_d), BLK'(is_d));
        chk("idle_stall_i", BLK'(o_stall_i), BLK'(!i_icache_hit));
        chk("idle_ar_valid", BLK'(o_ar_valid), '0);
        n0 = cyc;
        tick();
        i_addr_wb    = rnd64();
        i_data_block = {16{$urandom}};
        if (is_d) i_read_addr_d = rnd64();
        if (dirty) begin
            for (int i = 0; i <= ar_wait; i++) begin
                i_aw_ready = (i == ar_wait);
                #1;
                chk("aw_valid", BLK'(o_aw_valid), BLK'(1));
                chk("aw_addr", BLK'(o_aw_addr), BLK'(wb_addr & ALIGN));
                tick();
            end
            i_aw_ready = 1'b0;
            extra += ar_wait;
            k = 0;
            for (int g = 0; k < NB && g < 4 * NB; g++) begin
                rdy = w_toggle ? (g % 2 == 1) : 1'b1;
                i_w_ready = rdy;
                #1;
                chk("w_valid", BLK'(o_w_valid), BLK'(1));
                chk("w_data", BLK'(o_w_data), BLK'(victim[k*BW +: BW]));
                chk("w_last", BLK'(o_w_last), BLK'(k == NB - 1));
                chk("wb_stall_d", BLK'(o_stall_d), BLK'(1));
                tick();
                if (rdy) k++;
                else extra++;
            end
            i_w_ready = 1'b0;
            chk("wb_beats_sent", BLK'(k), BLK'(NB));
            for (int i = 0; i <= b_wait; i++) begin
                i_b_valid = (i == b_wait);
                #1;
                chk("resp_w_valid", BLK'(o_w_valid), '0);
                chk("resp_ar_valid", BLK'(o_ar_valid), '0);
                tick();
            end
            i_b_valid = 1'b0;
            extra += NB + 2 + b_wait;
        end
        for (int i = 0; i <= ar_wait; i++) begin
            i_ar_ready = (i == ar_wait);
            #1;
            chk("ar_valid", BLK'(o_ar_valid), BLK'(1));
            chk("ar_addr", BLK'(o_ar_addr), BLK'(miss_addr & ALIGN));
            chk("ar_aw_valid", BLK'(o_aw_valid), '0);
            tick();
        end
        i_ar_ready = 1'b0;
        extra += ar_wait;
        for (int b = 0; b < NB; b++) begin
            if (r_gaps && $urandom_range(0, 2) == 0) begin
                i_r_valid = 1'b0;
                #1;
                chk("gap_ar_valid", BLK'(o_ar_valid), '0);
                tick();
                extra++;
            end
            i_r_valid = 1'b1;
            i_r_data  = beats[b];
            i_r_last  = (b == last_at);
            exp_err   = exp_err | ((b == last_at) != (b == NB - 1));
            #1;
            chk("rd_stall_d", BLK'(o_stall_d), BLK'(is_d));
            chk("rd_stall_i", BLK'(o_stall_i), BLK'(is_d ? !i_icache_hit : 1'b1));
            chk("rd_instr_we", BLK'(o_instr_we), '0);
            tick();
        end
        i_r_valid = 1'b0;
        i_r_last  = 1'b0;
        if (is_d) i_mem_access = 1'b0;
        else i_icache_hit = 1'b1;
        #1;
        chk("fill_instr_we", BLK'(o_instr_we), BLK'(!is_d));
        chk("fill_dcache_we", BLK'(o_dcache_we), BLK'(is_d));
        chk("fill_block", o_data_block, exp_blk);
        chk("fill_latency", BLK'(cyc - n0), BLK'(NB + 2 + extra));
        chk("fill_proto_err", BLK'(o_proto_err), BLK'(exp_err));
        chk("fill_stall_i", BLK'(o_stall_i), BLK'(is_d ? !i_icache_hit : 1'b0));
        tick();
        #1;
        chk("post_instr_we", BLK'(o_instr_we), '0);
        chk("post_dcache_we", BLK'(o_dcache_we), '0);
        chk("post_block", o_data_block, exp_blk);
    endtask

    initial begin
        bit is_d, dirty;
        logic [AW-1:0] a, b;

        // reset state
        repeat (3) tick();
        #1;
        chk("rst_stall_i", BLK'(o_stall_i), '0);
        chk("rst_stall_d", BLK'(o_stall_d), '0);
        chk("rst_valids", BLK'({o_ar_valid, o_aw_valid, o_w_valid}), '0);
        chk("rst_we", BLK'({o_instr_we, o_dcache_we}), '0);
        chk("rst_proto_err", BLK'(o_proto_err), '0);
        chk("rst_block", o_data_block, '0);
        rst_n = 1'b1;
        tick();

        // D hit is not a miss
        i_mem_access = 1'b1;
        i_dcache_hit = 1'b1;
        #1;
        chk("hit_stall_d", BLK'(o_stall_d), '0);
        tick();
        i_mem_access = 1'b0;
        #1;
        chk("hit_ar_valid", BLK'(o_ar_valid), '0);

        // clean I miss, fixed beat pattern
        for (int k = 0; k < NB; k++) beats[k] = 64'h11 * 64'(k + 1);
        start_i(64'h1000_0004);
        run_service(1'b0, 1'b0, 64'h1000_0004, '0, 0, 0, 1'b0, NB - 1, 1'b0);
        chk("blk_lo", BLK'(o_data_block[63:0]), BLK'(64'h11));
        chk("blk_hi", BLK'(o_data_block[511:448]), BLK'(64'h88));

        // dirty D miss with victim pattern A0..A7
        for (int k = 0; k < NB; k++) victim[k*BW +: BW] = 64'hA0 + 64'(k);
        rand_beats();
        start_d(1'b1, 64'h0000_3000, 64'h2040);
        run_service(1'b1, 1'b1, 64'h0000_3000, 64'h2040, 0, 3, 1'b0, NB - 1, 1'b0);

        // simultaneous I and D: D first, I follows
        rand_beats();
        a = rnd64();
        b = rnd64();
        victim = {16{$urandom}};
        start_d(1'b0, a, rnd64());
        start_i(b);
        run_service(1'b1, 1'b0, a, '0, 0, 0, 1'b0, NB - 1, 1'b0);
        rand_beats();
        run_service(1'b0, 1'b0, b, '0, 0, 0, 1'b0, NB - 1, 1'b0);

        // ready back-pressure: AR/AW held 5 cycles, W ready toggling
        rand_beats();
        victim = {16{$urandom}};
        a = rnd64();
        b = rnd64();
        start_d(1'b1, a, b);
        run_service(1'b1, 1'b1, a, b, 5, 1, 1'b1, NB - 1, 1'b1);

        // early r_last on beat 5: error flagged, burst still runs to beat 7
        rand_beats();
        a = rnd64();
        start_i(a);
        run_service(1'b0, 1'b0, a, '0, 0, 0, 1'b0, 5, 1'b0);
        chk("proto_err_sticky", BLK'(o_proto_err), BLK'(1));

        // reset during beat 3 of a later burst
        rand_beats();
        start_i(rnd64());
        tick();
        i_ar_ready = 1'b1;
        tick();
        i_ar_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            i_r_valid = 1'b1;
            i_r_data  = beats[k];
            tick();
        end
        i_r_data     = beats[3];
        i_icache_hit = 1'b1;
        rst_n        = 1'b0;
        tick();
        rst_n     = 1'b1;
        i_r_valid = 1'b0;
        exp_err   = 1'b0;
        #1;
        chk("midrst_proto_err", BLK'(o_proto_err), '0);
        chk("midrst_block", o_data_block, '0);
        chk("midrst_stalls", BLK'({o_stall_i, o_stall_d}), '0);
        chk("midrst_valids", BLK'({o_ar_valid, o_aw_valid, o_w_valid}), '0);
        for (int i = 0; i < 3; i++) begin
            chk("midrst_no_strobe", BLK'({o_instr_we, o_dcache_we}), '0);
            tick();
        end

        // randomized misses
        for (int t = 0; t < 8; t++) begin
            rand_beats();
            victim = {16{$urandom}};
            is_d  = 1'($urandom_range(0, 1));
            dirty = is_d && ($urandom_range(0, 1) == 1);
            a = rnd64();
            b = rnd64();
            if (is_d) start_d(dirty, a, b);
            else start_i(a);
            run_service(is_d, dirty, a, b, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                        1'($urandom_range(0, 1)), NB - 1, 1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
